// File: rtl/choose_ctrl_pkg.sv
// Shared definitions for the pokemon choose scene: FSM encoding, grid geometry
// and the row/column to pokemon id mapping.
package choose_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PICK1 = 2'd1,
        ST_PICK2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int GRID_COLS = 4;
    localparam int GRID_ROWS = 2;
    localparam int POKE_MAX  = GRID_COLS * GRID_ROWS;
    localparam int COL_W     = $clog2(GRID_COLS);

    // id = row*GRID_COLS + col + 1; with four columns {row,col} already is row*4+col.
    function automatic logic [3:0] grid_id(input logic row, input logic [COL_W-1:0] col);
        return {1'b0, row, col} + 4'd1;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Cursor-frame blink generator: toggles `on` every BLINK_FRAMES ticks while enabled.
// A restart shows the frame immediately and starts a fresh half-period.
module blink_timer #(
    parameter int BLINK_FRAMES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    input  logic tick,
    output logic on
);

    logic [7:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
            on  <= 1'b0;
        end else if (restart) begin
            cnt <= 8'd0;
            on  <= 1'b1;
        end else if (!en) begin
            cnt <= 8'd0;
            on  <= 1'b0;
        end else if (tick) begin
            if (cnt == 8'(BLINK_FRAMES - 1)) begin
                cnt <= 8'd0;
                on  <= ~on;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/choose_ctrl.sv
// Two-player pokemon selection controller: cursor on a 4x2 grid, two distinct
// picks, handshake of the final result and a blinking cursor frame.
module choose_ctrl
    import choose_ctrl_pkg::*;
#(
    parameter int BLINK_FRAMES = 16,
    parameter int ID_W         = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scene_active,
    input  logic            vsync_tick,
    input  logic            btn_left,
    input  logic            btn_right,
    input  logic            btn_up,
    input  logic            btn_down,
    input  logic            btn_confirm,
    input  logic            btn_cancel,
    input  logic            sel_ack,
    output logic [ID_W-1:0] pokemon_id,
    output logic            frame_on,
    output logic [ID_W-1:0] p1_id,
    output logic [ID_W-1:0] p2_id,
    output logic            sel_valid,
    output logic [1:0]      state_o
);

    state_t           state, state_nx;
    logic             row, row_nx;
    logic [COL_W-1:0] col, col_nx;
    logic [ID_W-1:0]  p1_nx, p2_nx;
    logic [ID_W-1:0]  cursor_id;
    logic             moved, restart, picking, blink_on;

    assign cursor_id = ID_W'(grid_id(row, col));
    assign picking   = (state == ST_PICK1) || (state == ST_PICK2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            row   <= 1'b0;
            col   <= '0;
            p1_id <= '0;
            p2_id <= '0;
        end else begin
            state <= state_nx;
            row   <= row_nx;
            col   <= col_nx;
            p1_id <= p1_nx;
            p2_id <= p2_nx;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_nx = state;
        row_nx   = row;
        col_nx   = col;
        p1_nx    = p1_id;
        p2_nx    = p2_id;
        moved    = 1'b0;
        if (!scene_active || (state == ST_DONE && sel_ack) || state == ST_IDLE) begin
            // Scene abort, accepted result and fresh start all clear the picks.
            state_nx = (scene_active && state == ST_IDLE) ? ST_PICK1 : ST_IDLE;
            row_nx   = 1'b0;
            col_nx   = '0;
            p1_nx    = '0;
            p2_nx    = '0;
        end else if (picking) begin
            if (btn_cancel) begin
                if (state == ST_PICK2) begin
                    p1_nx    = '0;
                    state_nx = ST_PICK1;
                end
            end else if (btn_confirm) begin
                if (state == ST_PICK1) begin
                    p1_nx    = cursor_id;
                    state_nx = ST_PICK2;
                end else if (cursor_id != p1_id) begin
                    p2_nx    = cursor_id;
                    state_nx = ST_DONE;
                end
            end else if (btn_left) begin
                col_nx = col - 1'b1;  // column count is a power of two, wrap is free
                moved  = 1'b1;
            end else if (btn_right) begin
                col_nx = col + 1'b1;
                moved  = 1'b1;
            end else if (btn_up || btn_down) begin
                row_nx = ~row;
                moved  = 1'b1;
            end
        end
    end

    assign restart = ((state_nx == ST_PICK1) || (state_nx == ST_PICK2)) &&
                     (moved || (state_nx != state));

    blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk     (clk),
        .rst     (rst),
        .en      (picking),
        .restart (restart),
        .tick    (vsync_tick),
        .on      (blink_on)
    );

    assign pokemon_id = cursor_id;
    assign frame_on   = (state == ST_DONE) || (picking && blink_on);
    assign sel_valid  = (state == ST_DONE);
    assign state_o    = state;

endmodule

// File: tb/tb_choose_ctrl.sv
// Self-checking bench for choose_ctrl: directed scenarios then random stimulus,
// all compared against an integer-level model of the selection rules.
module tb_choose_ctrl;

    localparam int BF   = 2;
    localparam int ID_W = 8;

    logic clk = 1'b0, rst = 1'b1, scene_active = 1'b0, vsync_tick = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic btn_confirm = 1'b0, btn_cancel = 1'b0, sel_ack = 1'b0;
    logic [ID_W-1:0] pokemon_id, p1_id, p2_id;
    logic            frame_on, sel_valid;
    logic [1:0]      state_o;

    choose_ctrl #(.BLINK_FRAMES(BF), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .scene_active(scene_active), .vsync_tick(vsync_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .btn_confirm(btn_confirm), .btn_cancel(btn_cancel), .sel_ack(sel_ack),
        .pokemon_id(pokemon_id), .frame_on(frame_on), .p1_id(p1_id), .p2_id(p2_id),
        .sel_valid(sel_valid), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Model: phase 0=idle 1=pick1 2=pick2 3=done; cursor as plain id 1..8.
    int m_state, m_cur, m_p1, m_p2, m_frame, m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".id"},    32'(pokemon_id), 32'(m_cur));
        check({tag, ".frame"}, 32'(frame_on),   32'(m_frame));
        check({tag, ".p1"},    32'(p1_id),      32'(m_p1));
        check({tag, ".p2"},    32'(p2_id),      32'(m_p2));
        check({tag, ".valid"}, 32'(sel_valid),  32'(m_state == 3));
        check({tag, ".state"}, 32'(state_o),    32'(m_state));
    endtask

    task automatic model_reset();
        m_state = 0; m_cur = 1; m_p1 = 0; m_p2 = 0; m_frame = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        int ns, nc, np1, np2, row, col;
        bit moved;
        ns = m_state; nc = m_cur; np1 = m_p1; np2 = m_p2; moved = 0;
        row = (m_cur - 1) / 4;
        col = (m_cur - 1) % 4;
        if (!scene_active || m_state == 0 || (m_state == 3 && sel_ack)) begin
            ns = (scene_active && m_state == 0) ? 1 : 0;
            nc = 1; np1 = 0; np2 = 0;
        end else if (m_state != 3) begin
            if (btn_cancel) begin
                if (m_state == 2) begin np1 = 0; ns = 1; end
            end else if (btn_confirm) begin
                if (m_state == 1) begin np1 = m_cur; ns = 2; end
                else if (m_cur != m_p1) begin np2 = m_cur; ns = 3; end
            end else if (btn_left) begin
                nc = row * 4 + (col + 3) % 4 + 1; moved = 1;
            end else if (btn_right) begin
                nc = row * 4 + (col + 1) % 4 + 1; moved = 1;
            end else if (btn_up || btn_down) begin
                nc = (1 - row) * 4 + col + 1; moved = 1;
            end
        end
        if (ns == 0) begin
            m_frame = 0; m_cnt = 0;
        end else if (ns == 3) begin
            m_frame = 1; m_cnt = 0;
        end else if (moved || ns != m_state) begin
            m_frame = 1; m_cnt = 0;
        end else if (vsync_tick) begin
            if (m_cnt == BF - 1) begin m_cnt = 0; m_frame = 1 - m_frame; end
            else m_cnt++;
        end
        m_state = ns; m_cur = nc; m_p1 = np1; m_p2 = np2;
    endtask

    task automatic step(input string tag);
        if (rst) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        {btn_left, btn_right, btn_up, btn_down, btn_confirm, btn_cancel} = '0;
        vsync_tick = 1'b0;
        sel_ack    = 1'b0;
    endtask

    initial begin
        model_reset();
        step("reset");
        step("reset_hold");
        rst = 1'b0;
        step("idle_inactive");
        scene_active = 1'b1;
        step("enter_pick1");

        for (int i = 0; i < 4; i++) begin
            btn_right = 1'b1;
            step("right_wrap");
        end
        check("right_wrap_end", 32'(pokemon_id), 32'd1);

        btn_confirm = 1'b1; step("confirm_p1");
        check("p1_is_1", 32'(p1_id), 32'd1);
        btn_confirm = 1'b1; step("confirm_same_ignored");
        btn_right = 1'b1;   step("move_to_2");
        btn_confirm = 1'b1; step("confirm_p2");
        check("p2_is_2", 32'(p2_id), 32'd2);
        btn_left = 1'b1; btn_cancel = 1'b1; vsync_tick = 1'b1; step("done_ignores_buttons");
        sel_ack = 1'b1;     step("ack_to_idle");
        check("valid_drops", 32'(sel_valid), 32'd0);

        step("restart_pick1");
        btn_confirm = 1'b1; step("pick1_again");
        btn_cancel = 1'b1; btn_right = 1'b1; step("cancel_beats_right");
        check("cancel_state", 32'(state_o), 32'd1);
        btn_cancel = 1'b1; step("pick1_cancel_ignored");

        for (int i = 0; i < 8; i++) begin
            vsync_tick = 1'b1; step("blink_tick");
            step("blink_gap");
        end
        vsync_tick = 1'b1; step("blink_partial");
        btn_left = 1'b1;   step("move_restores_frame");
        check("frame_after_move", 32'(frame_on), 32'd1);

        btn_right = 1'b1; step("to_1");
        btn_down = 1'b1;  step("down_to_5");
        btn_left = 1'b1;  step("left_5_to_8");
        check("left_5_to_8", 32'(pokemon_id), 32'd8);
        btn_up = 1'b1; step("up_8_to_4");
        btn_left = 1'b1; step("left_to_3");
        btn_left = 1'b1; step("left_to_2");
        btn_up = 1'b1; step("up_2_to_6");
        check("up_2_to_6", 32'(pokemon_id), 32'd6);
        btn_right = 1'b1; step("right_to_7");
        btn_down = 1'b1; step("down_7_to_3");
        check("down_7_to_3", 32'(pokemon_id), 32'd3);

        btn_confirm = 1'b1; step("abort_p1");
        btn_up = 1'b1;      step("abort_move");
        btn_confirm = 1'b1; step("abort_p2");
        scene_active = 1'b0; sel_ack = 1'b1; step("abort_in_done");
        check("abort_state", 32'(state_o), 32'd0);
        scene_active = 1'b1; step("abort_reenter");
        btn_confirm = 1'b1;  step("rst_p1");
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        step("rst_hold");
        rst = 1'b0;
        step("rst_release");

        for (int i = 0; i < 600; i++) begin
            scene_active = ($urandom_range(31) != 0);
            vsync_tick   = ($urandom_range(2) == 0);
            btn_left     = ($urandom_range(3) == 0);
            btn_right    = ($urandom_range(3) == 0);
            btn_up       = ($urandom_range(3) == 0);
            btn_down     = ($urandom_range(3) == 0);
            btn_confirm  = ($urandom_range(2) == 0);
            btn_cancel   = ($urandom_range(7) == 0);
            sel_ack      = ($urandom_range(3) == 0);
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
